warp_scheduler: RTL and testbench
=================================

# warp_scheduler

Per-core warp scheduler for `compute_core`, parametrised in warp count and warp width. It launches up to `WARPS_PER_CORE` warps at a common start PC and builds each warp's execution mask, including a partial mask for the tail warp. It drives per-warp state and PC to the fetchers, issues one ready warp per cycle to the execution stage with round-robin fairness, retires warps on halt, and reports core `done`.

## Interface
- `WARPS_PER_CORE`, 4, warps managed; 1..16
- `THREADS_PER_WARP`, 32, lanes per warp; 1..32
- Local `WID = max(1, $clog2(WARPS_PER_CORE))`, `CW = $clog2(WARPS_PER_CORE)+1`, `CT = $clog2(THREADS_PER_WARP)+1`
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  launch pulse; honoured only when not RUN
- `active_warps`  in  CW  warps launched; values above `WARPS_PER_CORE` clamp
- `tail_threads`  in  CT  live lanes in the last active warp; 0 or ≥`THREADS_PER_WARP` means full
- `start_pc`  in  instruction_memory_address_t  initial PC for all warps
- `done`  out  1  all launched warps halted
- `warp_state`  out  warp_state_t[W]  per-warp state, to fetchers
- `pc`  out  instruction_memory_address_t[W]  per-warp PC, to fetchers
- `fetch_done`  in  W  per-warp instruction available (fetcher state FETCHED)
- `issue_valid`  out  1  a warp is offered for execution
- `issue_warp`  out  WID  offered warp index
- `issue_mask`  out  THREADS_PER_WARP  execution mask of the offered warp
- `issue_pc`  out  instruction_memory_address_t  PC of the offered warp
- `issue_ready`  in  1  execution stage accepts
- `retire_valid`  in  1  execution of one warp finished
- `retire_warp`  in  WID  retiring warp
- `retire_next_pc`  in  instruction_memory_address_t  next PC
- `retire_halt`  in  1  warp executed HALT

## Operation
- Core FSM: IDLE → RUN on `start`; RUN → FINISHED when every active warp is DONE; FINISHED → RUN on `start`. `start` is ignored in RUN.
- On launch, each warp i < clamped `active_warps` enters FETCH with `pc = start_pc`. Other warps enter or stay IDLE with a zero mask. Masks are registered at launch: all ones, except the last active warp, which gets its low `tail_threads` bits set.
- Per-warp states: IDLE, FETCH, READY, EXEC, DONE.
  - FETCH → READY on `fetch_done[i]`.
  - READY → EXEC on issue handshake.
  - EXEC → FETCH on retire with `retire_halt=0`; `pc ← retire_next_pc`.
  - EXEC → DONE on retire with `retire_halt=1`; pc holds.
- Issue selection: round-robin over READY warps, starting at `rr_ptr+1` mod W. `rr_ptr` updates to the issued warp on handshake only.
- `issue_valid`, `issue_warp`, `issue_mask` and `issue_pc` are combinational from registered state. They stay stable while `issue_valid & !issue_ready`.
- A retire naming a warp not in EXEC is ignored. A retire and an issue for different warps in the same cycle are both applied.
- `active_warps = 0`: launch enters RUN with no warps, and `done` rises the next cycle.

## Timing
- Reset (async assert): core IDLE, all warps IDLE, `pc = 0`, masks 0, `rr_ptr = W-1` (warp 0 wins first), `done = 0`, `issue_valid = 0`. Deassertion is synchronous to `clk`.
- `start` sampled at edge N → warps in FETCH from N+1.
- `fetch_done` at N → READY at N+1, so `issue_valid` can assert in cycle N+1.
- Handshake at N → EXEC at N+1. Throughput is one issue per cycle across warps; a single warp issues at most once per fetch.
- Last halt retire at N → DONE at N+1 → `done` = 1 at N+2. `done` is registered and held until the next `start`, and clears the cycle after that `start`.
- A `start` asserted in the same cycle that `done` would rise is ignored, because the core is still in RUN.

## Structure
- Shared package gets:
  - `warp_state_t` enum {WARP_IDLE, WARP_FETCH, WARP_READY, WARP_EXEC, WARP_DONE}
  - `core_state_t` {CORE_IDLE, CORE_RUN, CORE_FINISHED}
  - `instruction_memory_address_t`, reused as-is
- Sub-module `rr_arbiter #(N)`: inputs `req[N]` and `ptr`; outputs `grant_valid` and `grant_idx`. It is purely combinational; the pointer register lives in `warp_scheduler`.

## Test plan
- W=4, T=32, `active_warps=4`, `tail_threads=0`, `start_pc=0x10`; all `fetch_done` at one cycle; `issue_ready=1` → issues warps 0,1,2,3 on consecutive cycles, each with mask 0xFFFFFFFF and pc 0x10.
- `active_warps=3`, `tail_threads=5` → warp 2 mask 0x0000001F, warp 3 stays IDLE with mask 0 and is never issued.
- Warps 1 and 3 READY, `rr_ptr=1`, `issue_ready` held 0 for 3 cycles → `issue_warp=3` stable all 3 cycles; on accept, warp 1 issues next.
- Retire warp 2 with `next_pc=0x24`, `halt=0` → warp 2 in FETCH with pc 0x24; halt retires for all warps → `done` rises 2 cycles after the last halt, and a `start` in RUN is ignored.
- `reset` asserted low mid-RUN with warps in EXEC → all outputs return to reset values immediately, with no clock edge needed; `active_warps=0` launch → `done=1` one cycle after `start`.

Source files
------------

// File: rtl/warp_scheduler_pkg.sv
// Shared types for the per-core warp scheduler: warp/core state encodings,
// the instruction address type and the lane-mask builder.
package warp_scheduler_pkg;

  typedef logic [31:0] instruction_memory_address_t;

  typedef enum logic [2:0] {
    WARP_IDLE  = 3'd0,
    WARP_FETCH = 3'd1,
    WARP_READY = 3'd2,
    WARP_EXEC  = 3'd3,
    WARP_DONE  = 3'd4
  } warp_state_t;

  typedef enum logic [1:0] {
    CORE_IDLE     = 2'd0,
    CORE_RUN      = 2'd1,
    CORE_FINISHED = 2'd2
  } core_state_t;

  // Low `live` lanes of a `width`-lane warp; 0 or >= width means all lanes.
  function automatic logic [31:0] lane_mask(input int unsigned live, input int unsigned width);
    logic [31:0] m;
    m = 32'd0;
    for (int unsigned b = 0; b < 32; b++) begin
      if ((b < width) && ((live == 32'd0) || (live >= width) || (b < live))) begin
        m[b] = 1'b1;
      end else begin
        m[b] = 1'b0;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/warp_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first requester after ptr, wrapping.
// The pointer itself is owned by the instantiating block.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          grant_valid,
  output logic [IW-1:0] grant_idx
);

  localparam int unsigned NU = N;

  // Scan N candidates starting one past the pointer; lowest distance wins.
  always_comb begin
    int unsigned cand;
    grant_valid = 1'b0;
    grant_idx   = {IW{1'b0}};
    cand        = 32'd0;
    for (int unsigned k = 1; k <= NU; k++) begin
      cand = (32'(ptr) + k) % NU;
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = IW'(cand);
      end else begin
        grant_valid = grant_valid;
      end
    end
  end

endmodule

// File: rtl/warp_scheduler.sv
// Per-core warp scheduler: launches warps, tracks per-warp state/PC/mask,
// issues one ready warp per cycle round-robin and reports core completion.
module warp_scheduler
  import warp_scheduler_pkg::*;
#(
  parameter int WARPS_PER_CORE   = 4,
  parameter int THREADS_PER_WARP = 32,
  localparam int WID = (WARPS_PER_CORE > 1) ? $clog2(WARPS_PER_CORE) : 1,
  localparam int CW  = $clog2(WARPS_PER_CORE) + 1,
  localparam int CT  = $clog2(THREADS_PER_WARP) + 1
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic                                              start,
  input  logic [CW-1:0]                                     active_warps,
  input  logic [CT-1:0]                                     tail_threads,
  input  instruction_memory_address_t                       start_pc,
  output logic                                              done,
  output warp_state_t [WARPS_PER_CORE-1:0]                  warp_state,
  output instruction_memory_address_t [WARPS_PER_CORE-1:0]  pc,
  input  logic [WARPS_PER_CORE-1:0]                         fetch_done,
  output logic                                              issue_valid,
  output logic [WID-1:0]                                    issue_warp,
  output logic [THREADS_PER_WARP-1:0]                       issue_mask,
  output instruction_memory_address_t                       issue_pc,
  input  logic                                              issue_ready,
  input  logic                                              retire_valid,
  input  logic [WID-1:0]                                    retire_warp,
  input  instruction_memory_address_t                       retire_next_pc,
  input  logic                                              retire_halt
);

  localparam int W = WARPS_PER_CORE;
  localparam int T = THREADS_PER_WARP;

  core_state_t                            core_state_r, core_state_next_s;
  warp_state_t [W-1:0]                    warp_state_r, warp_state_next_s;
  instruction_memory_address_t [W-1:0]    pc_r, pc_next_s;
  logic [W-1:0][T-1:0]                    mask_r, mask_next_s;
  logic [WID-1:0]                         rr_ptr_r, rr_ptr_next_s;
  logic                                   hold_r, hold_next_s;
  logic [WID-1:0]                         hold_idx_r, hold_idx_next_s;
  logic                                   done_r, done_next_s;

  logic [CW-1:0]  clamp_s;
  logic           launch_s;
  logic [W-1:0]   req_s;
  logic           arb_valid_s;
  logic [WID-1:0] arb_idx_s;
  logic [WID-1:0] sel_idx_s;
  logic           handshake_s;
  logic           all_done_s;
  logic [31:0]    tail_mask_s;

  assign clamp_s  = (active_warps > CW'(W)) ? CW'(W) : active_warps;
  assign launch_s = start && (core_state_r != CORE_RUN);

  // Ready-warp request vector for the arbiter.
  always_comb begin
    req_s = {W{1'b0}};
    for (int i = 0; i < W; i++) begin
      req_s[i] = (warp_state_r[i] == WARP_READY);
    end
  end

  rr_arbiter #(.N(W)) u_arb (
    .req         (req_s),
    .ptr         (rr_ptr_r),
    .grant_valid (arb_valid_s),
    .grant_idx   (arb_idx_s)
  );

  // A stalled offer is pinned so late-arriving ready warps cannot displace it.
  assign sel_idx_s   = hold_r ? hold_idx_r : arb_idx_s;
  assign issue_valid = hold_r | arb_valid_s;
  assign issue_warp  = sel_idx_s;
  assign issue_mask  = issue_valid ? mask_r[sel_idx_s] : {T{1'b0}};
  assign issue_pc    = issue_valid ? pc_r[sel_idx_s] : 32'd0;
  assign handshake_s = issue_valid & issue_ready;

  assign warp_state = warp_state_r;
  assign pc         = pc_r;
  assign done       = done_r;

  // Per-warp next state, PC and mask: launch overrides normal progression.
  always_comb begin
    warp_state_next_s = warp_state_r;
    pc_next_s         = pc_r;
    mask_next_s       = mask_r;
    all_done_s        = 1'b1;
    tail_mask_s       = lane_mask(32'(tail_threads), 32'(T));
    for (int i = 0; i < W; i++) begin
      if ((warp_state_r[i] != WARP_IDLE) && (warp_state_r[i] != WARP_DONE)) begin
        all_done_s = 1'b0;
      end else begin
        all_done_s = all_done_s;
      end
      if (launch_s) begin
        if (CW'(i) < clamp_s) begin
          warp_state_next_s[i] = WARP_FETCH;
          pc_next_s[i]         = start_pc;
          mask_next_s[i]       = ((CW'(i) + CW'(1)) == clamp_s) ? tail_mask_s[T-1:0] : {T{1'b1}};
        end else begin
          warp_state_next_s[i] = WARP_IDLE;
          mask_next_s[i]       = {T{1'b0}};
        end
      end else begin
        case (warp_state_r[i])
          WARP_FETCH: begin
            if (fetch_done[i]) warp_state_next_s[i] = WARP_READY;
            else               warp_state_next_s[i] = WARP_FETCH;
          end
          WARP_READY: begin
            if (handshake_s && (sel_idx_s == WID'(i))) warp_state_next_s[i] = WARP_EXEC;
            else                                       warp_state_next_s[i] = WARP_READY;
          end
          WARP_EXEC: begin
            if (retire_valid && (retire_warp == WID'(i))) begin
              if (retire_halt) begin
                warp_state_next_s[i] = WARP_DONE;
              end else begin
                warp_state_next_s[i] = WARP_FETCH;
                pc_next_s[i]         = retire_next_pc;
              end
            end else begin
              warp_state_next_s[i] = WARP_EXEC;
            end
          end
          default: warp_state_next_s[i] = warp_state_r[i];
        endcase
      end
    end
  end

  // Core FSM, done flag, round-robin pointer and stall pin.
  always_comb begin
    core_state_next_s = core_state_r;
    done_next_s       = done_r;
    rr_ptr_next_s     = handshake_s ? sel_idx_s : rr_ptr_r;
    hold_next_s       = issue_valid & ~issue_ready;
    hold_idx_next_s   = sel_idx_s;
    case (core_state_r)
      CORE_IDLE, CORE_FINISHED: begin
        if (start) begin
          core_state_next_s = CORE_RUN;
          done_next_s       = 1'b0;
        end else begin
          core_state_next_s = core_state_r;
        end
      end
      CORE_RUN: begin
        if (all_done_s) begin
          core_state_next_s = CORE_FINISHED;
          done_next_s       = 1'b1;
        end else begin
          core_state_next_s = CORE_RUN;
        end
      end
      default: core_state_next_s = CORE_IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      core_state_r <= CORE_IDLE;
      warp_state_r <= {W{WARP_IDLE}};
      pc_r         <= {W{32'd0}};
      mask_r       <= {(W*T){1'b0}};
      rr_ptr_r     <= WID'(W - 1);
      hold_r       <= 1'b0;
      hold_idx_r   <= {WID{1'b0}};
      done_r       <= 1'b0;
    end else begin
      core_state_r <= core_state_next_s;
      warp_state_r <= warp_state_next_s;
      pc_r         <= pc_next_s;
      mask_r       <= mask_next_s;
      rr_ptr_r     <= rr_ptr_next_s;
      hold_r       <= hold_next_s;
      hold_idx_r   <= hold_idx_next_s;
      done_r       <= done_next_s;
    end
  end

endmodule

// File: tb/tb_warp_scheduler.sv
// Directed bench for warp_scheduler (W=4, T=32): launch, tail masks,
// round-robin stall stability, retire/halt/done timing, async reset, clamp.
module tb_warp_scheduler;
  import warp_scheduler_pkg::*;

  localparam int W = 4;
  localparam int T = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic [2:0] active_warps = 3'd0;
  logic [5:0] tail_threads = 6'd0;
  instruction_memory_address_t start_pc = 32'd0;
  logic done;
  warp_state_t [W-1:0] warp_state;
  instruction_memory_address_t [W-1:0] pc;
  logic [W-1:0] fetch_done = 4'd0;
  logic issue_valid;
  logic [1:0] issue_warp;
  logic [T-1:0] issue_mask;
  instruction_memory_address_t issue_pc;
  logic issue_ready = 1'b0;
  logic retire_valid = 1'b0;
  logic [1:0] retire_warp = 2'd0;
  instruction_memory_address_t retire_next_pc = 32'd0;
  logic retire_halt = 1'b0;

  int checks = 0;
  int errors = 0;

  warp_scheduler #(.WARPS_PER_CORE(W), .THREADS_PER_WARP(T)) dut (
    .clk(clk), .reset(reset), .start(start), .active_warps(active_warps),
    .tail_threads(tail_threads), .start_pc(start_pc), .done(done),
    .warp_state(warp_state), .pc(pc), .fetch_done(fetch_done),
    .issue_valid(issue_valid), .issue_warp(issue_warp), .issue_mask(issue_mask),
    .issue_pc(issue_pc), .issue_ready(issue_ready), .retire_valid(retire_valid),
    .retire_warp(retire_warp), .retire_next_pc(retire_next_pc), .retire_halt(retire_halt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [2:0] aw, input logic [5:0] tt, input logic [31:0] spc);
    active_warps = aw; tail_threads = tt; start_pc = spc; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic retire(input logic [1:0] w, input logic [31:0] npc, input logic halt);
    retire_valid = 1'b1; retire_warp = w; retire_next_pc = npc; retire_halt = halt;
    step();
    retire_valid = 1'b0; retire_halt = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int c = 0; c < 6 && done !== 1'b1; c++) step();
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL %s: done=%b expected 1", name, done); end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (done !== 1'b0 || issue_valid !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: done=%b issue_valid=%b expected 0/0", done, issue_valid);
    end
    for (int i = 0; i < W; i++) begin
      checks++;
      if (warp_state[i] !== WARP_IDLE || pc[i] !== 32'd0) begin
        errors++; $display("FAIL reset_warp%0d: state=%0d pc=%h expected 0/0", i, warp_state[i], pc[i]);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    step();
  endtask

  task automatic test_launch_full();
    launch(3'd4, 6'd0, 32'h10);
    for (int i = 0; i < W; i++) begin
      checks++;
      if (warp_state[i] !== WARP_FETCH || pc[i] !== 32'h10) begin
        errors++; $display("FAIL launch_warp%0d: state=%0d pc=%h expected FETCH/10", i, warp_state[i], pc[i]);
      end
    end
    fetch_done = 4'hF; step(); fetch_done = 4'h0;
    issue_ready = 1'b1;
    for (int k = 0; k < W; k++) begin
      checks++;
      if (issue_valid !== 1'b1 || issue_warp !== 2'(k) || issue_mask !== 32'hFFFF_FFFF || issue_pc !== 32'h10) begin
        errors++; $display("FAIL full_issue%0d: v=%b w=%0d m=%h pc=%h expected 1/%0d/ffffffff/10",
                           k, issue_valid, issue_warp, issue_mask, issue_pc, k);
      end
      step();
    end
    issue_ready = 1'b0;
    checks++;
    if (issue_valid !== 1'b0 || warp_state[3] !== WARP_EXEC) begin
      errors++; $display("FAIL full_drain: v=%b state3=%0d expected 0/EXEC", issue_valid, warp_state[3]);
    end
    for (int k = 0; k < W; k++) retire(2'(k), 32'd0, 1'b1);
    wait_done("full_done");
  endtask

  task automatic test_tail_mask();
    logic [31:0] exp_mask [3];
    exp_mask[0] = 32'hFFFF_FFFF; exp_mask[1] = 32'hFFFF_FFFF; exp_mask[2] = 32'h0000_001F;
    launch(3'd3, 6'd5, 32'h40);
    checks++;
    if (done !== 1'b0 || warp_state[3] !== WARP_IDLE || warp_state[2] !== WARP_FETCH) begin
      errors++; $display("FAIL tail_launch: done=%b s3=%0d s2=%0d expected 0/IDLE/FETCH", done, warp_state[3], warp_state[2]);
    end
    fetch_done = 4'hF; step(); fetch_done = 4'h0;
    issue_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (issue_valid !== 1'b1 || issue_warp !== 2'(k) || issue_mask !== exp_mask[k]) begin
        errors++; $display("FAIL tail_issue%0d: v=%b w=%0d m=%h expected 1/%0d/%h",
                           k, issue_valid, issue_warp, issue_mask, k, exp_mask[k]);
      end
      step();
    end
    issue_ready = 1'b0;
    checks++;
    if (issue_valid !== 1'b0 || warp_state[3] !== WARP_IDLE) begin
      errors++; $display("FAIL tail_idle3: v=%b s3=%0d expected 0/IDLE", issue_valid, warp_state[3]);
    end
    for (int k = 0; k < 3; k++) retire(2'(k), 32'd0, 1'b1);
    wait_done("tail_done");
  endtask

  task automatic test_rr_stall();
    launch(3'd4, 6'd0, 32'h100);
    fetch_done = 4'b0011; step(); fetch_done = 4'h0;
    issue_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (issue_warp !== 2'(k) || issue_valid !== 1'b1) begin
        errors++; $display("FAIL rr_pre%0d: v=%b w=%0d expected 1/%0d", k, issue_valid, issue_warp, k);
      end
      step();
    end
    issue_ready = 1'b0;
    retire(2'd1, 32'h200, 1'b0);
    fetch_done = 4'b1010; step(); fetch_done = 4'h0;
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (issue_valid !== 1'b1 || issue_warp !== 2'd3) begin
        errors++; $display("FAIL rr_stall%0d: v=%b w=%0d expected 1/3", s, issue_valid, issue_warp);
      end
      if (s == 0) fetch_done = 4'b0100;
      step();
      fetch_done = 4'h0;
    end
    issue_ready = 1'b1;
    checks++;
    if (issue_warp !== 2'd3 || issue_pc !== 32'h100) begin
      errors++; $display("FAIL rr_accept3: w=%0d pc=%h expected 3/100", issue_warp, issue_pc);
    end
    step();
    checks++;
    if (issue_valid !== 1'b1 || issue_warp !== 2'd1 || issue_pc !== 32'h200) begin
      errors++; $display("FAIL rr_next1: v=%b w=%0d pc=%h expected 1/1/200", issue_valid, issue_warp, issue_pc);
    end
    step();
    checks++;
    if (issue_valid !== 1'b1 || issue_warp !== 2'd2) begin
      errors++; $display("FAIL rr_next2: v=%b w=%0d expected 1/2", issue_valid, issue_warp);
    end
    step();
    issue_ready = 1'b0;
    for (int k = 0; k < W; k++) retire(2'(k), 32'd0, 1'b1);
    wait_done("rr_done");
  endtask

  task automatic test_retire_done();
    launch(3'd4, 6'd0, 32'h10);
    fetch_done = 4'hF; step(); fetch_done = 4'h0;
    issue_ready = 1'b1;
    for (int k = 0; k < W; k++) step();
    issue_ready = 1'b0;
    retire(2'd2, 32'h24, 1'b0);
    checks++;
    if (warp_state[2] !== WARP_FETCH || pc[2] !== 32'h24) begin
      errors++; $display("FAIL retire_fetch: s2=%0d pc2=%h expected FETCH/24", warp_state[2], pc[2]);
    end
    retire(2'd2, 32'h99, 1'b1);
    checks++;
    if (warp_state[2] !== WARP_FETCH || pc[2] !== 32'h24) begin
      errors++; $display("FAIL retire_ignored: s2=%0d pc2=%h expected FETCH/24", warp_state[2], pc[2]);
    end
    fetch_done = 4'b0100; step(); fetch_done = 4'h0;
    checks++;
    if (issue_valid !== 1'b1 || issue_warp !== 2'd2 || issue_pc !== 32'h24) begin
      errors++; $display("FAIL reissue2: v=%b w=%0d pc=%h expected 1/2/24", issue_valid, issue_warp, issue_pc);
    end
    issue_ready = 1'b1; step(); issue_ready = 1'b0;
    start = 1'b1; active_warps = 3'd1;
    retire(2'd0, 32'd0, 1'b1);
    start = 1'b0;
    checks++;
    if (warp_state[0] !== WARP_DONE || warp_state[1] !== WARP_EXEC) begin
      errors++; $display("FAIL start_in_run: s0=%0d s1=%0d expected DONE/EXEC", warp_state[0], warp_state[1]);
    end
    retire(2'd1, 32'd0, 1'b1);
    retire(2'd2, 32'd0, 1'b1);
    retire(2'd3, 32'd0, 1'b1);
    checks++;
    if (warp_state[3] !== WARP_DONE || done !== 1'b0) begin
      errors++; $display("FAIL last_halt: s3=%0d done=%b expected DONE/0", warp_state[3], done);
    end
    start = 1'b1; active_warps = 3'd4;
    step();
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || warp_state[0] !== WARP_DONE) begin
      errors++; $display("FAIL done_rise: done=%b s0=%0d expected 1/DONE", done, warp_state[0]);
    end
    step();
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL done_hold: done=%b expected 1", done); end
  endtask

  task automatic test_async_reset_zero_clamp();
    launch(3'd4, 6'd0, 32'h10);
    fetch_done = 4'hF; step(); fetch_done = 4'h0;
    issue_ready = 1'b1; step(); step(); issue_ready = 1'b0;
    #3 reset = 1'b0;
    #1;
    checks++;
    if (done !== 1'b0 || issue_valid !== 1'b0 || warp_state !== {W{WARP_IDLE}} || pc !== {W{32'd0}}) begin
      errors++; $display("FAIL async_reset: done=%b v=%b states=%h expected 0/0/0", done, issue_valid, warp_state);
    end
    #2 reset = 1'b1;
    launch(3'd0, 6'd0, 32'h0);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL zero_launch_run: done=%b expected 0", done); end
    step();
    checks++;
    if (done !== 1'b1 || issue_valid !== 1'b0) begin
      errors++; $display("FAIL zero_launch_done: done=%b v=%b expected 1/0", done, issue_valid);
    end
    launch(3'd7, 6'd3, 32'h80);
    checks++;
    if (warp_state !== {W{WARP_FETCH}}) begin
      errors++; $display("FAIL clamp_launch: states=%h expected all FETCH", warp_state);
    end
    fetch_done = 4'b1001; step(); fetch_done = 4'h0;
    issue_ready = 1'b1;
    checks++;
    if (issue_warp !== 2'd0 || issue_mask !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL rr_reset_ptr: w=%0d m=%h expected 0/ffffffff", issue_warp, issue_mask);
    end
    step();
    checks++;
    if (issue_warp !== 2'd3 || issue_mask !== 32'h0000_0007 || issue_pc !== 32'h80) begin
      errors++; $display("FAIL clamp_tail: w=%0d m=%h pc=%h expected 3/00000007/80", issue_warp, issue_mask, issue_pc);
    end
    step();
    issue_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_launch_full();
    test_tail_mask();
    test_rr_stall();
    test_retire_done();
    test_async_reset_zero_clamp();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
